bram_access_ctrl: RTL and testbench
===================================

Name: bram_access_ctrl

Overview:
- Initiator-side controller for the team's single-port synchronous BRAM: write enable, address, write data, registered read data, 1-cycle read latency.
- Accepts single writes and burst reads from a user-side valid/ready request channel.
- Drives the BRAM port directly.
- Returns read data on a valid/ready response channel with full backpressure, sustaining 1 word/cycle when unthrottled.

Parameters:
- ADDR_WIDTH, 13, BRAM address width; must match the attached RAM.
- DATA_WIDTH, 32, BRAM data width.
- LEN_WIDTH, 4, burst length field width; a burst is 1..2**LEN_WIDTH words.

Ports:
- clk  in  1  single clock for the block and the BRAM.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_we  in  1  1 = single write, 0 = burst read.
- req_addr  in  ADDR_WIDTH  start address.
- req_wdata  in  DATA_WIDTH  write data; ignored for reads.
- req_len  in  LEN_WIDTH  burst length minus 1; ignored for writes.
- rsp_valid  out  1  read word available.
- rsp_ready  in  1  consumer takes the word.
- rsp_data  out  DATA_WIDTH  read word.
- rsp_last  out  1  final word of the burst.
- busy  out  1  burst in progress or response data pending.
- ram_we  out  1  BRAM write enable.
- ram_addr  out  ADDR_WIDTH  BRAM address.
- ram_din  out  DATA_WIDTH  BRAM write data.
- ram_dout  in  DATA_WIDTH  BRAM registered read data, valid one cycle after the address.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state -> IDLE; response FIFO emptied; in-flight flag cleared; burst counters cleared.
  - While rst_n is low: req_ready=0, rsp_valid=0, ram_we=0, busy=0.
- FSM states: IDLE, READ.
- IDLE:
  - req_ready=1.
  - Write accept (req_valid & req_we): ram_we=1, ram_addr=req_addr, ram_din=req_wdata in the same cycle (combinational); stay in IDLE.
  - Read accept (req_valid & !req_we): latch cur_addr=req_addr, remaining=req_len; go to READ; no RAM access in the accept cycle.
  - Writes may be accepted while earlier read words still sit in the FIFO.
- READ:
  - req_ready=0; ram_we=0; ram_addr=cur_addr.
  - Issue condition: (fifo_count + inflight - pop) < 2, where pop = rsp_valid & rsp_ready in this cycle.
  - On issue: set inflight for the next cycle, tag it last if remaining==0, increment cur_addr, decrement remaining.
  - The issue with remaining==0 returns to IDLE.
  - No issue: hold cur_addr and remaining.
- Read data capture: in the cycle after an issue, ram_dout plus the last tag are pushed into the FIFO at the closing edge.
- Response FIFO:
  - 2 entries, first-word fall-through; rsp_valid = count!=0.
  - Simultaneous push and pop is legal at any count, including full.
  - The credit rule guarantees no push when the FIFO is full and not popping; overflow is impossible.
- Latency: accept at cycle T -> ram_addr driven at T+1 -> rsp_valid at T+3.
- Throughput: with rsp_ready held high, one word per cycle after that.
- Address wrap: cur_addr increments modulo 2**ADDR_WIDTH (max address -> 0); no error.
- Width rules: remaining is LEN_WIDTH bits; burst length = req_len + 1, so len 0 gives 1 word and all-ones gives 2**LEN_WIDTH words.
- busy = (state==READ) | inflight | (count!=0).
- Reset mid-burst:
  - Burst aborted; FIFO contents and the in-flight word are discarded.
  - No rsp_valid until a new request is accepted.
  - RAM contents are unaffected (ram_we=0 during reset).
- Response channel rule: rsp_data and rsp_last stay stable while rsp_valid & !rsp_ready.

Decomposition:
- Shared package bram_ctrl_pkg:
  - FSM state enumeration (IDLE, READ).
  - Constant RSP_FIFO_DEPTH = 2.
  - Constant RAM_READ_LATENCY = 1.
- Sub-module bram_rsp_skid: 2-entry FWFT FIFO of width DATA_WIDTH+1 (data + last), with push, pop, count and synchronous active-low reset.
- The controller FSM and the credit logic stay in bram_access_ctrl.

Test Plan:
- Attach the team BRAM model (ADDR_WIDTH 13). Write 0xA5A5_0001..0xA5A5_0004 to addresses 0x010..0x013 on consecutive cycles. Then read at addr 0x010, len 3 with rsp_ready=1 -> four words in order on consecutive cycles; rsp_last only on 0xA5A5_0004; first rsp_valid exactly 3 cycles after accept.
- Single-word read at 0x000, len 0 -> one response, rsp_last=1; busy drops the cycle after the pop.
- Read at 0x1FFE, len 3 -> data from 0x1FFE, 0x1FFF, 0x0000, 0x0001 (wrap).
- Read len 15 with rsp_ready toggling 1,0,0,1,… and a random pattern -> all 16 words delivered in order with none lost or duplicated; rsp_data stable while stalled; never more than 2 words buffered.
- Deassert rst_n for 1 cycle after the 2nd word of an 8-word burst -> rsp_valid=0 and busy=0 the next cycle; a new read of 0x011 len 0 then returns the correct word.
- Issue a write while req_ready=0 (state READ) -> request held; write performed only after the burst's last issue returns to IDLE; read-back confirms the value.

Source files
------------

// File: rtl/bram_ctrl_pkg.sv
// Shared types and constants for the BRAM access controller.
package bram_ctrl_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRead = 1'b1
    } ctrl_state_e;

    // Response buffer depth; also the read credit limit.
    localparam int unsigned RSP_FIFO_DEPTH   = 2;
    // Cycles from address to registered read data on the attached RAM.
    localparam int unsigned RAM_READ_LATENCY = 1;

endpackage

// File: rtl/bram_rsp_skid.sv
// Two-entry first-word-fall-through buffer for read responses.
module bram_rsp_skid
    import bram_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic [1:0]       count_q, count_d;
    logic             pop_en;

    // Next-state for the head/tail entries; entry0 is always the head.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        pop_en   = pop && (count_q != 2'd0);
        unique case ({push, pop_en})
            2'b10: begin
                if (count_q == 2'd0) entry0_d = din;
                else                 entry1_d = din;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                entry0_d = entry1_q;
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    entry0_d = din;
                end else begin
                    entry0_d = entry1_q;
                    entry1_d = din;
                end
            end
            default: ;
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign dout  = entry0_q;
    assign count = count_q;

endmodule

// File: rtl/bram_access_ctrl.sv
// Request/response front end for a single-port BRAM: single writes, burst reads.
module bram_access_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  busy,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH:0]   fifo_dout;
    logic                  pop;
    logic                  issue;
    logic [2:0]            credit;

    assign pop = rsp_valid && rsp_ready;

    // Words committed to the buffer once in-flight data lands, net of this cycle's pop.
    assign credit = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue  = (state_q == StRead) && (credit < 3'(RSP_FIFO_DEPTH));

    // FSM next-state, burst bookkeeping and RAM port drive.
    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        remaining_d     = remaining_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        req_ready       = 1'b0;
        ram_we          = 1'b0;
        ram_addr        = cur_addr_q;
        unique case (state_q)
            StIdle: begin
                req_ready = rst_n;
                ram_addr  = req_addr;
                if (req_valid && rst_n) begin
                    if (req_we) begin
                        ram_we = 1'b1;
                    end else begin
                        cur_addr_d  = req_addr;
                        remaining_d = req_len;
                        state_d     = StRead;
                    end
                end
            end
            StRead: begin
                if (issue) begin
                    inflight_d      = 1'b1;
                    inflight_last_d = (remaining_q == '0);
                    cur_addr_d      = cur_addr_q + ADDR_WIDTH'(1);
                    remaining_d     = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == '0) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            cur_addr_q      <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    // RAM output is valid the cycle after an issue; capture it with its last tag.
    bram_rsp_skid #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_rsp_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   ({inflight_last_q, ram_dout}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign ram_din   = req_wdata;
    assign rsp_valid = rst_n && (fifo_count != 2'd0);
    assign rsp_data  = fifo_dout[DATA_WIDTH-1:0];
    assign rsp_last  = fifo_dout[DATA_WIDTH];
    assign busy      = rst_n && ((state_q == StRead) || inflight_q || (fifo_count != 2'd0));

endmodule

// File: tb/tb_bram_access_ctrl.sv
// Directed bench for bram_access_ctrl with an attached BRAM model and response scoreboard.
module tb_bram_access_ctrl;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [LW-1:0] req_len;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic          busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    always #5 clk = ~clk;

    bram_access_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Single-port BRAM model, registered read.
    logic [DW-1:0] mem [1<<AW];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int            n_vec = 0;
    int            n_err = 0;
    int            pops  = 0;
    logic [DW:0]   sb [$];
    logic [DW-1:0] ref_mem [1<<AW];
    logic          prev_stall = 1'b0;
    logic [DW:0]   prev_word;
    logic [DW:0]   exp_word;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response monitor: scoreboard pops, stall stability, buffer occupancy.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("stall_valid", 64'(rsp_valid), 64'(1));
                check("stall_stable", 64'({rsp_last, rsp_data}), 64'(prev_word));
            end
            if (busy) check("fifo_depth", 64'(dut.u_rsp_skid.count <= 2'd2), 64'(1));
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    exp_word = sb.pop_front();
                    check("rsp_word", 64'({rsp_last, rsp_data}), 64'(exp_word));
                end
                pops++;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_word  = {rsp_last, rsp_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Present a request (called just after a posedge); returns just after the accepting edge.
    task automatic send_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [LW-1:0] len, output int waits);
        logic [AW-1:0] a;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_len   = len;
        waits     = 0;
        @(negedge clk);
        while (!req_ready && waits < 200) begin
            check("held_no_we", 64'(ram_we), 64'(0));
            waits++;
            @(negedge clk);
        end
        check("req_ready", 64'(req_ready), 64'(1));
        if (we) begin
            check("wr_we", 64'(ram_we), 64'(1));
            check("wr_addr", 64'(ram_addr), 64'(addr));
            check("wr_din", 64'(ram_din), 64'(wdata));
            ref_mem[addr] = wdata;
        end else begin
            check("rd_no_we", 64'(ram_we), 64'(0));
            for (int i = 0; i <= int'(len); i++) begin
                a = addr + AW'(i);
                sb.push_back({(i == int'(len)), ref_mem[a]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drop_req();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(sb.size()), 64'(0));
        check(tag, 64'(busy), 64'(0));
    endtask

    task automatic preload(input logic [AW-1:0] start, input int n);
        int w;
        for (int i = 0; i < n; i++) send_req(1'b1, start + AW'(i), $urandom(), '0, w);
        drop_req();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int k;
        int base;
        int n;

        // Reset, with a write request presented to prove ram_we is gated.
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = '0;
        req_wdata = 32'hFFFF_FFFF;
        req_len   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_ram_we", 64'(ram_we), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drop_req();
        @(negedge clk);
        check("idle_req_ready", 64'(req_ready), 64'(1));
        check("idle_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;

        // Preload the regions later bursts read from.
        preload(13'h1FFE, 4);
        preload(13'h040, 16);
        preload(13'h100, 4);
        preload(13'h200, 8);

        // Consecutive writes then a 4-word read with latency and throughput checks.
        send_req(1'b1, 13'h010, 32'hA5A5_0001, '0, w);
        send_req(1'b1, 13'h011, 32'hA5A5_0002, '0, w);
        send_req(1'b1, 13'h012, 32'hA5A5_0003, '0, w);
        send_req(1'b1, 13'h013, 32'hA5A5_0004, '0, w);
        drop_req();
        base = pops;
        send_req(1'b0, 13'h010, '0, 4'd3, w);
        drop_req();
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) check("rd_ram_addr", 64'(ram_addr), 64'(13'h010));
        end while (!rsp_valid && k < 10);
        check("rd_latency", 64'(k), 64'(3));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check("burst4_pops", 64'(pops - base), 64'(4));
        check("burst4_busy", 64'(busy), 64'(0));

        // Single-word read: last set, busy clears the cycle after the pop.
        base = pops;
        send_req(1'b0, 13'h000, '0, 4'd0, w);
        drop_req();
        repeat (3) @(negedge clk);
        check("single_valid", 64'(rsp_valid), 64'(1));
        check("single_last", 64'(rsp_last), 64'(1));
        check("single_busy", 64'(busy), 64'(1));
        @(negedge clk);
        check("single_busy_drop", 64'(busy), 64'(0));
        check("single_pops", 64'(pops - base), 64'(1));
        @(posedge clk);
        #1;

        // Address wrap.
        base = pops;
        send_req(1'b0, 13'h1FFE, '0, 4'd3, w);
        drop_req();
        wait_idle("wrap_idle");
        check("wrap_pops", 64'(pops - base), 64'(4));

        // 16-word burst, ready pattern 1,0,0 repeating.
        base = pops;
        send_req(1'b0, 13'h040, '0, 4'd15, w);
        drop_req();
        for (int c = 0; c < 400 && (sb.size() != 0 || busy); c++) begin
            rsp_ready = (c % 3 == 0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        check("bp_pops", 64'(pops - base), 64'(16));
        check("bp_sb", 64'(sb.size()), 64'(0));

        // 16-word burst, random ready.
        base = pops;
        send_req(1'b0, 13'h040, '0, 4'd15, w);
        drop_req();
        for (int c = 0; c < 400 && (sb.size() != 0 || busy); c++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        check("rnd_pops", 64'(pops - base), 64'(16));
        check("rnd_sb", 64'(sb.size()), 64'(0));

        // Reset after the 2nd word of an 8-word burst.
        base = pops;
        send_req(1'b0, 13'h200, '0, 4'd7, w);
        drop_req();
        n = 0;
        while (pops - base < 2 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_mid_wait", 64'(pops - base), 64'(2));
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 64'(rsp_valid), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_we", 64'(ram_we), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        check("post_rst_valid", 64'(rsp_valid), 64'(0));
        check("post_rst_busy", 64'(busy), 64'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_quiet", 64'(rsp_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        base = pops;
        send_req(1'b0, 13'h011, '0, 4'd0, w);
        drop_req();
        wait_idle("post_rst_idle");
        check("post_rst_pops", 64'(pops - base), 64'(1));

        // Write held off during a burst, performed once the FSM is back in IDLE.
        base = pops;
        send_req(1'b0, 13'h100, '0, 4'd3, w);
        send_req(1'b1, 13'h012, 32'hDEAD_BEEF, '0, w);
        check("held_wait_cycles", 64'(w), 64'(4));
        drop_req();
        wait_idle("held_idle");
        check("held_pops", 64'(pops - base), 64'(4));
        base = pops;
        send_req(1'b0, 13'h012, '0, 4'd0, w);
        drop_req();
        wait_idle("readback_idle");
        check("readback_pops", 64'(pops - base), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
